// File: rtl/ref_gen.sv
// Programmable square-wave reference for closed-loop PLL testing: phase-accumulator NCO with
// triangular frequency sweep, phase jumps and timed output dropout.
module ref_gen #(
  parameter int unsigned XTAL_FREQ        = 50000000,
  // 125 kHz expressed as Hz * 65536 / XTAL_FREQ
  parameter int unsigned FREQ_DEFAULT_RAW = 32'((64'd125000 << 16) / 64'(XTAL_FREQ))
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic [9:0]  freq_set,
  input  logic        freq_load,
  input  logic        sweep_en,
  input  logic [9:0]  sweep_lo,
  input  logic [9:0]  sweep_hi,
  input  logic [15:0] sweep_div,
  input  logic [15:0] phase_jump,
  input  logic        jump_req,
  input  logic [15:0] dropout_cycles,
  input  logic        dropout_req,
  output logic        ref_out,
  output logic [9:0]  freq_cur,
  output logic [1:0]  state,
  output logic        sweep_err
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StSweepUp = 2'd1,
    StSweepDn = 2'd2,
    StDrop    = 2'd3
  } state_e;

  localparam logic [9:0] FreqRst = FREQ_DEFAULT_RAW[9:0];

  state_e      state_q, saved_q;
  logic [15:0] acc_q, step_q, dcnt_q;
  logic [9:0]  freq_q;
  logic        ref_q, err_q;

  logic        drop_start, drop_exit, in_drop_next, sweep_ok, step_hit;
  logic [9:0]  freq_inc, freq_dec;
  logic [15:0] acc_d;

  always_comb begin
    drop_start   = dropout_req && (dropout_cycles != 16'd0);
    drop_exit    = (state_q == StDrop) && !drop_start && (dcnt_q == 16'd1);
    // ref_out is gated by the next state so the low window matches the dropout length exactly
    in_drop_next = drop_start || ((state_q == StDrop) && !drop_exit);
    sweep_ok     = sweep_lo < sweep_hi;
    step_hit     = step_q == sweep_div;
    freq_inc     = freq_q + 10'd1;
    freq_dec     = freq_q - 10'd1;
    acc_d        = acc_q + {6'b0, freq_q} + (jump_req ? phase_jump : 16'd0);
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= 16'd0;
      ref_q   <= 1'b0;
      freq_q  <= FreqRst;
      state_q <= StRun;
      saved_q <= StRun;
      step_q  <= 16'd0;
      dcnt_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ref_q <= in_drop_next ? 1'b0 : acc_q[15];
      if (drop_start) begin
        dcnt_q <= dropout_cycles;
        if (state_q != StDrop) saved_q <= state_q;
        state_q <= StDrop;
      end else begin
        unique case (state_q)
          StRun: begin
            if (sweep_en && sweep_ok) begin
              state_q <= StSweepUp;
              step_q  <= 16'd0;
              if (freq_q < sweep_lo || freq_q > sweep_hi) freq_q <= sweep_lo;
            end else begin
              if (sweep_en) err_q <= 1'b1;
              if (freq_load) freq_q <= freq_set;
            end
          end
          StSweepUp: begin
            if (!sweep_en) begin
              state_q <= StRun;
            end else if (step_hit) begin
              step_q <= 16'd0;
              freq_q <= freq_inc;
              if (freq_inc >= sweep_hi) state_q <= StSweepDn;
            end else begin
              step_q <= step_q + 16'd1;
            end
          end
          StSweepDn: begin
            if (!sweep_en) begin
              state_q <= StRun;
            end else if (step_hit) begin
              step_q <= 16'd0;
              freq_q <= freq_dec;
              if (freq_dec <= sweep_lo) state_q <= StSweepUp;
            end else begin
              step_q <= step_q + 16'd1;
            end
          end
          StDrop: begin
            if (dcnt_q == 16'd1) begin
              dcnt_q  <= 16'd0;
              state_q <= saved_q;
            end else begin
              dcnt_q <= dcnt_q - 16'd1;
            end
          end
          default: state_q <= StRun;
        endcase
      end
    end
  end

  assign ref_out   = ref_q;
  assign freq_cur  = freq_q;
  assign state     = state_q;
  assign sweep_err = err_q;

endmodule

// File: tb/tb_ref_gen.sv
// Directed self-checking bench for ref_gen: reset, NCO timing, load, jump, sweep, dropout, error.
module tb_ref_gen;

  logic        clk_50 = 1'b0;
  logic        rst_n;
  logic [9:0]  freq_set;
  logic        freq_load;
  logic        sweep_en;
  logic [9:0]  sweep_lo, sweep_hi;
  logic [15:0] sweep_div, phase_jump, dropout_cycles;
  logic        jump_req, dropout_req;
  logic        ref_out;
  logic [9:0]  freq_cur;
  logic [1:0]  state;
  logic        sweep_err;

  int n_cmp = 0;
  int n_bad = 0;

  ref_gen dut (
    .clk_50        (clk_50),
    .rst_n         (rst_n),
    .freq_set      (freq_set),
    .freq_load     (freq_load),
    .sweep_en      (sweep_en),
    .sweep_lo      (sweep_lo),
    .sweep_hi      (sweep_hi),
    .sweep_div     (sweep_div),
    .phase_jump    (phase_jump),
    .jump_req      (jump_req),
    .dropout_cycles(dropout_cycles),
    .dropout_req   (dropout_req),
    .ref_out       (ref_out),
    .freq_cur      (freq_cur),
    .state         (state),
    .sweep_err     (sweep_err)
  );

  always #5 clk_50 = ~clk_50;

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advances until the sample where ref_out has just gone high; bounded.
  task automatic wait_rise(input string tag);
    logic prev;
    logic found;
    prev  = ref_out;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      if (ref_out && !prev) found = 1'b1;
      prev = ref_out;
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  int fseq [6] = '{100, 101, 102, 101, 100, 101};
  int sseq [6] = '{1, 1, 2, 2, 1, 1};

  initial begin
    int early_hi, hi_cnt, lo_cnt, bad, d;
    rst_n = 1'b0;
    freq_set = '0; freq_load = 1'b0; sweep_en = 1'b0; sweep_lo = '0; sweep_hi = '0;
    sweep_div = '0; phase_jump = '0; jump_req = 1'b0; dropout_cycles = '0; dropout_req = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_ref", {31'd0, ref_out}, 32'd0);
    check("rst_freq", {22'd0, freq_cur}, 32'd163);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_err", {31'd0, sweep_err}, 32'd0);

    // First rising edge lands on clock 203 after release
    @(negedge clk_50) rst_n = 1'b1;
    early_hi = 0;
    for (int k = 1; k <= 203; k++) begin
      tick();
      if (k < 202 && ref_out) early_hi++;
      if (k == 202) check("rise_202", {31'd0, ref_out}, 32'd0);
      if (k == 203) check("rise_203", {31'd0, ref_out}, 32'd1);
    end
    check("no_early_rise", early_hi, 32'd0);

    // Load 512: period 128, 64/64 duty
    freq_set = 10'd512; freq_load = 1'b1;
    tick();
    freq_load = 1'b0;
    check("load_freq", {22'd0, freq_cur}, 32'd512);
    wait_rise("rise_512");
    hi_cnt = 0; lo_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      if (ref_out) hi_cnt++; else lo_cnt++;
      tick();
    end
    check("duty_hi", hi_cnt, 32'd64);
    check("duty_lo", lo_cnt, 32'd64);
    check("period_rise", {31'd0, ref_out}, 32'd1);

    // Half-turn jump ten clocks into the high phase inverts the output
    wait_rise("rise_jump");
    repeat (9) tick();
    phase_jump = 16'h8000; jump_req = 1'b1;
    tick();
    jump_req = 1'b0;
    check("jump_pre", {31'd0, ref_out}, 32'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ref_out !== 1'b0) bad++;
    end
    check("jump_inverted", bad, 32'd0);
    check("jump_freq", {22'd0, freq_cur}, 32'd512);

    // Zero-length dropout is ignored
    dropout_cycles = 16'd0; dropout_req = 1'b1;
    tick();
    dropout_req = 1'b0;
    check("drop_zero", {30'd0, state}, 32'd0);

    // Triangular sweep 100..102, step every 4 clocks; freq_load ignored mid-sweep
    rst_n = 1'b0;
    sweep_lo = 10'd100; sweep_hi = 10'd102; sweep_div = 16'd3; sweep_en = 1'b1;
    freq_set = 10'd5;
    tick();
    @(negedge clk_50) rst_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      check($sformatf("sweep_freq_%0d", k), {22'd0, freq_cur}, fseq[(k-1)/4]);
      check($sformatf("sweep_state_%0d", k), {30'd0, state}, sseq[(k-1)/4]);
      freq_load = (k == 10);
    end
    freq_load = 1'b0;

    // Dropout of 1000 clocks mid-sweep, output low and freq frozen
    dropout_cycles = 16'd1000; dropout_req = 1'b1;
    tick();
    dropout_req = 1'b0;
    d = 0; bad = 0;
    for (int i = 0; i < 2000 && state == 2'd3; i++) begin
      d++;
      if (ref_out !== 1'b0 || freq_cur !== 10'd101) bad++;
      tick();
    end
    check("drop_len", d, 32'd1000);
    check("drop_low_frozen", bad, 32'd0);
    check("drop_ret_state", {30'd0, state}, 32'd1);
    check("drop_ret_freq", {22'd0, freq_cur}, 32'd101);
    tick();
    check("post_drop_state", {30'd0, state}, 32'd2);
    check("post_drop_freq", {22'd0, freq_cur}, 32'd102);

    // Re-request at clock 500 stretches the dropout to 1500
    dropout_req = 1'b1;
    tick();
    d = 0; bad = 0;
    for (int i = 0; i < 3000 && state == 2'd3; i++) begin
      d++;
      if (ref_out !== 1'b0) bad++;
      dropout_req = (d == 500);
      tick();
    end
    dropout_req = 1'b0;
    check("ext_len", d, 32'd1500);
    check("ext_low", bad, 32'd0);
    check("ext_ret_state", {30'd0, state}, 32'd2);

    // Sweep disable returns to RUN holding frequency
    sweep_en = 1'b0;
    tick();
    check("sweep_off_state", {30'd0, state}, 32'd0);
    check("sweep_off_freq", {22'd0, freq_cur}, 32'd102);

    // Invalid sweep bounds: sticky error, cleared only by reset
    sweep_lo = 10'd200; sweep_hi = 10'd200; sweep_en = 1'b1;
    repeat (5) tick();
    check("err_state", {30'd0, state}, 32'd0);
    check("err_flag", {31'd0, sweep_err}, 32'd1);
    sweep_en = 1'b0;
    tick();
    check("err_sticky", {31'd0, sweep_err}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("err_async_clr", {31'd0, sweep_err}, 32'd0);
    check("rst_async_freq", {22'd0, freq_cur}, 32'd163);
    @(negedge clk_50) rst_n = 1'b1;
    tick();
    check("err_after_rst", {31'd0, sweep_err}, 32'd0);
    check("state_after_rst", {30'd0, state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
